// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// Module   : if_stage
// Purpose  : Instruction-fetch stage; waits on / buffers the SRAM response,
//            drops flush-orphaned responses, flags ADEF, drives IF->ID.
// Revision : 1.0
// ============================================================================
module if_stage #(
  parameter int                PC_W     = 32,
  parameter int                INST_W   = 32,
  parameter logic [INST_W-1:0] NOP_INST = 32'h0340_0000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     if_valid_i,
  input  logic                     inst_en_i,
  input  logic [PC_W-1:0]          pc_i,
  input  logic                     inst_data_ok_i,
  input  logic [INST_W-1:0]        inst_rdata_i,
  input  logic                     id_allowin_i,
  input  logic                     flush_i,
  output logic                     if_allowin_o,
  output logic                     if_to_id_valid_o,
  output logic [PC_W+INST_W:0]     to_id_obus
);

  logic              buf_valid;
  logic [INST_W-1:0] buf_inst;
  logic              cancel;

  logic              adef;
  logic              live_ok;
  logic              ready_go;
  logic              buf_set;
  logic              buf_clr;
  logic              cancel_set;
  logic [INST_W-1:0] inst;

  assign adef     = (pc_i[1:0] != 2'b00);
  // A response arriving while cancel is set belongs to a flushed entry.
  assign live_ok  = inst_data_ok_i & ~cancel;
  assign ready_go = if_valid_i & (adef | ~inst_en_i | buf_valid | live_ok);

  assign if_to_id_valid_o = ready_go & ~flush_i;
  assign if_allowin_o     = ~if_valid_i | flush_i | (ready_go & id_allowin_i);

  always_comb begin
    inst = inst_rdata_i;
    if (~inst_en_i | adef) begin
      inst = NOP_INST;
    end else if (buf_valid) begin
      inst = buf_inst;
    end
  end

  assign to_id_obus = {adef, pc_i, inst};

  assign buf_set    = if_valid_i & inst_en_i & live_ok & ~buf_valid & ~id_allowin_i & ~flush_i;
  assign buf_clr    = (if_to_id_valid_o & id_allowin_i) | flush_i;
  assign cancel_set = flush_i & if_valid_i & inst_en_i & ~adef & ~buf_valid & ~inst_data_ok_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_valid <= 1'b0;
      buf_inst  <= '0;
    end else if (buf_clr) begin
      buf_valid <= 1'b0;
    end else if (buf_set) begin
      buf_valid <= 1'b1;
      buf_inst  <= inst_rdata_i;
    end
  end

  // Only one request can be outstanding, so one pending orphan is enough.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cancel <= 1'b0;
    end else if (cancel_set) begin
      cancel <= 1'b1;
    end else if (cancel && inst_data_ok_i) begin
      cancel <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_stage
// Purpose  : Self-checking bench for if_stage (vector table + scoreboard).
// Revision : 1.0
// ============================================================================
module tb_if_stage;

  localparam logic [31:0] NOP = 32'h0340_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_valid_i = 1'b0;
  logic        inst_en_i = 1'b0;
  logic [31:0] pc_i = '0;
  logic        inst_data_ok_i = 1'b0;
  logic [31:0] inst_rdata_i = '0;
  logic        id_allowin_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        if_allowin_o;
  logic        if_to_id_valid_o;
  logic [64:0] to_id_obus;

  int checks = 0;
  int failures = 0;
  logic [64:0] sb_q[$];

  if_stage dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .if_valid_i       (if_valid_i),
    .inst_en_i        (inst_en_i),
    .pc_i             (pc_i),
    .inst_data_ok_i   (inst_data_ok_i),
    .inst_rdata_i     (inst_rdata_i),
    .id_allowin_i     (id_allowin_i),
    .flush_i          (flush_i),
    .if_allowin_o     (if_allowin_o),
    .if_to_id_valid_o (if_to_id_valid_o),
    .to_id_obus       (to_id_obus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [64:0] mk(input logic a, input logic [31:0] pc, input logic [31:0] ins);
    return {a, pc, ins};
  endfunction

  // Scoreboard: every ID handshake must match the oldest expected transfer.
  always @(negedge clk) begin
    if (rst_n && if_to_id_valid_o && id_allowin_i) begin
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected: got %h expected no transfer", to_id_obus);
      end else begin
        logic [64:0] e;
        e = sb_q.pop_front();
        if (to_id_obus !== e) begin
          failures++;
          $display("FAIL sb_bus: got %h expected %h", to_id_obus, e);
        end
      end
    end
  end

  task automatic drv(input logic v, input logic en, input logic [31:0] pc, input logic ok,
                     input logic [31:0] rd, input logic al, input logic fl);
    if_valid_i = v; inst_en_i = en; pc_i = pc; inst_data_ok_i = ok;
    inst_rdata_i = rd; id_allowin_i = al; flush_i = fl;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0; #1; rst_n = 1'b1;
  endtask

  typedef struct {
    logic        v, en;
    logic [31:0] pc;
    logic        ok;
    logic [31:0] rd;
    logic        al, fl;
    logic        ev, ea;
    logic [64:0] eb;
  } vec_t;

  vec_t tbl[10];

  initial begin
    tbl[0] = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, mk(1'b0, 32'h0, NOP)};
    tbl[1] = '{1'b1, 1'b1, 32'h1c000000, 1'b1, 32'h02800421, 1'b1, 1'b0, 1'b1, 1'b1, mk(1'b0, 32'h1c000000, 32'h02800421)};
    tbl[2] = '{1'b1, 1'b0, 32'h1c000002, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 1'b1, mk(1'b1, 32'h1c000002, NOP)};
    tbl[3] = '{1'b1, 1'b1, 32'h1c000004, 1'b0, 32'h5555,     1'b1, 1'b0, 1'b0, 1'b0, mk(1'b0, 32'h1c000004, 32'h5555)};
    tbl[4] = '{1'b1, 1'b1, 32'h1c000008, 1'b1, 32'h77,       1'b0, 1'b0, 1'b1, 1'b0, mk(1'b0, 32'h1c000008, 32'h77)};
    tbl[5] = '{1'b1, 1'b1, 32'h1c00000c, 1'b1, 32'h99,       1'b1, 1'b1, 1'b0, 1'b1, mk(1'b0, 32'h1c00000c, 32'h99)};
    tbl[6] = '{1'b1, 1'b1, 32'h1c000001, 1'b0, 32'h88,       1'b0, 1'b0, 1'b1, 1'b0, mk(1'b1, 32'h1c000001, NOP)};
    tbl[7] = '{1'b1, 1'b0, 32'h1c000010, 1'b0, 32'h66,       1'b0, 1'b0, 1'b1, 1'b0, mk(1'b0, 32'h1c000010, NOP)};
    tbl[8] = '{1'b1, 1'b1, 32'h1c000014, 1'b0, 32'h44,       1'b1, 1'b1, 1'b0, 1'b1, mk(1'b0, 32'h1c000014, 32'h44)};
    tbl[9] = '{1'b0, 1'b1, 32'h1c000018, 1'b1, 32'h33,       1'b1, 1'b0, 1'b0, 1'b1, mk(1'b0, 32'h1c000018, 32'h33)};

    // Reset state
    #2;
    chk("rst_valid", 65'(if_to_id_valid_o), 65'd0);
    chk("rst_allowin", 65'(if_allowin_o), 65'd1);
    chk("rst_buf_valid", 65'(dut.buf_valid), 65'd0);
    chk("rst_cancel", 65'(dut.cancel), 65'd0);
    rst_n = 1'b1;

    // Single-cycle vectors, each from a freshly reset state
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      pulse_reset();
      drv(tbl[i].v, tbl[i].en, tbl[i].pc, tbl[i].ok, tbl[i].rd, tbl[i].al, tbl[i].fl);
      if (tbl[i].ev && tbl[i].al) sb_q.push_back(tbl[i].eb);
      @(negedge clk);
      chk($sformatf("vec%0d_valid", i), 65'(if_to_id_valid_o), 65'(tbl[i].ev));
      chk($sformatf("vec%0d_allowin", i), 65'(if_allowin_o), 65'(tbl[i].ea));
      chk($sformatf("vec%0d_bus", i), to_id_obus, tbl[i].eb);
    end

    // Buffered response held while ID stalls, leaves on the 4th cycle
    next_cycle(); pulse_reset();
    drv(1, 1, 32'h1c000040, 1, 32'h1234, 0, 0);
    next_cycle();
    for (int c = 1; c <= 3; c++) begin
      drv(1, 1, 32'h1c000040, 0, 32'hffff, (c == 3), 0);
      if (c == 3) sb_q.push_back(mk(1'b0, 32'h1c000040, 32'h1234));
      @(negedge clk);
      chk($sformatf("buf_c%0d_bufv", c), 65'(dut.buf_valid), 65'd1);
      chk($sformatf("buf_c%0d_valid", c), 65'(if_to_id_valid_o), 65'd1);
      chk($sformatf("buf_c%0d_bus", c), to_id_obus, mk(1'b0, 32'h1c000040, 32'h1234));
      next_cycle();
    end
    drv(0, 0, 32'h0, 0, 32'h0, 1, 0);
    chk("buf_after_bufv", 65'(dut.buf_valid), 65'd0);
    chk("buf_after_valid", 65'(if_to_id_valid_o), 65'd0);

    // Flush with request outstanding: orphan dropped, next response forwarded
    next_cycle(); pulse_reset();
    drv(1, 1, 32'h1c000020, 0, 32'h0, 1, 0);
    @(negedge clk);
    chk("fl_wait_valid", 65'(if_to_id_valid_o), 65'd0);
    next_cycle();
    drv(1, 1, 32'h1c000020, 0, 32'h0, 1, 1);
    @(negedge clk);
    chk("fl_flush_allowin", 65'(if_allowin_o), 65'd1);
    next_cycle();
    drv(1, 1, 32'h1c000100, 1, 32'hdead, 1, 0);
    @(negedge clk);
    chk("fl_cancel_set", 65'(dut.cancel), 65'd1);
    chk("fl_orphan_valid", 65'(if_to_id_valid_o), 65'd0);
    chk("fl_orphan_allowin", 65'(if_allowin_o), 65'd0);
    next_cycle();
    drv(1, 1, 32'h1c000100, 1, 32'hbeef, 1, 0);
    sb_q.push_back(mk(1'b0, 32'h1c000100, 32'hbeef));
    @(negedge clk);
    chk("fl_cancel_clr", 65'(dut.cancel), 65'd0);
    chk("fl_new_valid", 65'(if_to_id_valid_o), 65'd1);
    next_cycle();
    drv(0, 0, 32'h0, 0, 32'h0, 1, 0);

    // Asynchronous reset clears the buffer mid-cycle
    next_cycle(); pulse_reset();
    drv(1, 1, 32'h1c000050, 1, 32'haaaa, 0, 0);
    next_cycle();
    drv(1, 1, 32'h1c000050, 0, 32'h0, 0, 0);
    chk("ar_buf_pre", 65'(dut.buf_valid), 65'd1);
    rst_n = 1'b0; #1;
    chk("ar_buf_clr", 65'(dut.buf_valid), 65'd0);
    chk("ar_inst_clr", 65'(dut.buf_inst), 65'd0);
    if_valid_i = 1'b0; #1;
    chk("ar_valid", 65'(if_to_id_valid_o), 65'd0);
    rst_n = 1'b1;

    // Asynchronous reset clears a pending cancel mid-cycle
    next_cycle();
    drv(1, 1, 32'h1c000060, 0, 32'h0, 1, 1);
    next_cycle();
    drv(0, 0, 32'h0, 0, 32'h0, 0, 0);
    chk("ar_cancel_pre", 65'(dut.cancel), 65'd1);
    rst_n = 1'b0; #1;
    chk("ar_cancel_clr", 65'(dut.cancel), 65'd0);
    rst_n = 1'b1;

    // Flush coinciding with data_ok and ID handshake: dropped, no cancel
    next_cycle(); pulse_reset();
    drv(1, 1, 32'h1c000070, 1, 32'h1111, 1, 1);
    @(negedge clk);
    chk("fd_valid", 65'(if_to_id_valid_o), 65'd0);
    chk("fd_allowin", 65'(if_allowin_o), 65'd1);
    next_cycle();
    chk("fd_cancel", 65'(dut.cancel), 65'd0);
    drv(1, 1, 32'h1c000080, 1, 32'h4242, 1, 0);
    sb_q.push_back(mk(1'b0, 32'h1c000080, 32'h4242));
    @(negedge clk);
    chk("fd_next_valid", 65'(if_to_id_valid_o), 65'd1);
    next_cycle();
    drv(0, 0, 32'h0, 0, 32'h0, 0, 0);
    @(negedge clk);

    chk("sb_drained", 65'(sb_q.size()), 65'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
